// File: rtl/wb_stage_mq_pkg.sv
// ============================================================================
// Module  : wb_stage_mq_pkg
// Brief   : Shared lane-bus layout, queue entry type and lane decode helpers
//           for the multi-lane writeback stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_stage_mq_pkg;

   localparam int WS_LANE_BUS_WD = 74;
   localparam int WS_RF_PORT_WD  = 41;

   // Lane bus layout: {rf_wen[3:0], gr_we, dest[4:0], result[31:0], pc[31:0]}
   localparam int LB_PC_LSB     = 0;
   localparam int LB_RESULT_LSB = 32;
   localparam int LB_DEST_LSB   = 64;
   localparam int LB_GR_WE_BIT  = 69;
   localparam int LB_RF_WEN_LSB = 70;

   typedef struct packed {
      logic [3:0]  wen;
      logic [4:0]  dest;
      logic [31:0] data;
      logic [31:0] pc;
   } ws_entry_t;

   function automatic ws_entry_t unpack_lane(input logic [WS_LANE_BUS_WD-1:0] lane);
      ws_entry_t e;
      e.wen  = lane[LB_RF_WEN_LSB +: 4];
      e.dest = lane[LB_DEST_LSB +: 5];
      e.data = lane[LB_RESULT_LSB +: 32];
      e.pc   = lane[LB_PC_LSB +: 32];
      return e;
   endfunction

   // A lane is worth queueing only if it really changes an architectural register
   function automatic logic lane_writes(input logic [WS_LANE_BUS_WD-1:0] lane);
      return lane[LB_GR_WE_BIT] && (lane[LB_RF_WEN_LSB +: 4] != 4'h0)
             && (lane[LB_DEST_LSB +: 5] != 5'd0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_stage_mq_fwd_lookup.sv
// ============================================================================
// Module  : wb_fwd_lookup
// Brief   : One forwarding port: per byte, picks the youngest pending queue
//           entry that writes the looked-up register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fwd_lookup
   import wb_stage_mq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  ws_entry_t                    queue [DEPTH],
   input  logic [DEPTH-1:0]             valid,
   input  logic [$clog2(DEPTH)-1:0]     head,
   input  logic [4:0]                   raddr,
   output logic [3:0]                   hit,
   output logic [31:0]                  data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] slot;

   // Walk oldest to youngest so a later match overrides an earlier one
   always_comb begin
      hit  = '0;
      data = '0;
      slot = '0;
      for (int a = 0; a < DEPTH; a++) begin
         slot = head + PTR_W'(a);
         if (valid[slot] && (raddr != 5'd0) && (queue[slot].dest == raddr)) begin
            for (int b = 0; b < 4; b++) begin
               if (queue[slot].wen[b]) begin
                  hit[b]        = 1'b1;
                  data[8*b +: 8] = queue[slot].data[8*b +: 8];
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/wb_stage_mq.sv
// ============================================================================
// Module  : wb_stage_mq
// Brief   : Multi-lane writeback stage with in-order write queue, multi-port
//           RF drain and forwarding lookups (built only with WS_FWD_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage_mq
   import wb_stage_mq_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int DEPTH  = 4,
   parameter int WPORTS = 1,
   parameter int NFWD   = 2
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [LANES-1:0]              ms_to_ws_valid,
   input  logic [LANES*WS_LANE_BUS_WD-1:0] ms_to_ws_bus,
   output logic                          ws_allowin,
   input  logic                          ws_stall,
   output logic                          ws_empty,
   output logic [WPORTS*4-1:0]           rf_we,
   output logic [WPORTS*5-1:0]           rf_waddr,
   output logic [WPORTS*32-1:0]          rf_wdata,
   input  logic [NFWD*5-1:0]             fwd_raddr,
   output logic [NFWD*4-1:0]             fwd_hit,
   output logic [NFWD*32-1:0]            fwd_data,
   output logic [WPORTS*32-1:0]          debug_wb_pc,
   output logic [WPORTS*4-1:0]           debug_wb_rf_wen,
   output logic [WPORTS*5-1:0]           debug_wb_rf_wnum,
   output logic [WPORTS*32-1:0]          debug_wb_rf_wdata
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   ws_entry_t        queue [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;

   logic [LANES-1:0] accept;
   logic [PTR_W-1:0] enq_slot [LANES];
   logic [CNT_W-1:0] pushed, drained;
   logic             push;

   logic [PTR_W-1:0] port_slot [WPORTS];
   logic [3:0]       raw_we    [WPORTS];
   logic [3:0]       younger;

   assign ws_allowin = (count <= CNT_W'(DEPTH - LANES));
   assign ws_empty   = (count == '0);
   assign push       = (|ms_to_ws_valid) && ws_allowin;
   assign drained    = ws_stall ? '0 : ((count < CNT_W'(WPORTS)) ? count : CNT_W'(WPORTS));

   // Accepted lanes pack densely from the tail in lane order
   always_comb begin
      accept   = '0;
      pushed   = '0;
      enq_slot = '{default: '0};
      for (int i = 0; i < LANES; i++) begin
         accept[i]   = ms_to_ws_valid[i] && lane_writes(ms_to_ws_bus[WS_LANE_BUS_WD*i +: WS_LANE_BUS_WD]);
         enq_slot[i] = tail + PTR_W'(pushed);
         if (accept[i]) pushed = pushed + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(drained);
         if (push) tail <= tail + PTR_W'(pushed);
         count <= count + (push ? pushed : '0) - drained;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = 0; i < LANES; i++) begin
            if (accept[i]) queue[enq_slot[i]] <= unpack_lane(ms_to_ws_bus[WS_LANE_BUS_WD*i +: WS_LANE_BUS_WD]);
         end
      end
   end

   always_comb begin
      port_slot = '{default: '0};
      raw_we    = '{default: '0};
      for (int k = 0; k < WPORTS; k++) begin
         port_slot[k] = head + PTR_W'(k);
         raw_we[k]    = (CNT_W'(k) < drained) ? queue[port_slot[k]].wen : 4'h0;
      end
   end

   // A younger port writing the same register takes the overlapping bytes
   always_comb begin
      rf_we       = '0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      debug_wb_pc = '0;
      younger     = '0;
      for (int j = 0; j < WPORTS; j++) begin
         younger = '0;
         for (int k = j + 1; k < WPORTS; k++) begin
            if (queue[port_slot[k]].dest == queue[port_slot[j]].dest) younger = younger | raw_we[k];
         end
         rf_we[4*j +: 4]        = raw_we[j] & ~younger;
         rf_waddr[5*j +: 5]     = queue[port_slot[j]].dest;
         rf_wdata[32*j +: 32]   = queue[port_slot[j]].data;
         debug_wb_pc[32*j +: 32] = queue[port_slot[j]].pc;
      end
   end

   assign debug_wb_rf_wen   = rf_we;
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

`ifdef WS_FWD_EN
   logic [DEPTH-1:0] valid_mask;
   logic [PTR_W-1:0] age;

   always_comb begin
      valid_mask = '0;
      age        = '0;
      for (int s = 0; s < DEPTH; s++) begin
         age           = PTR_W'(s) - head;
         valid_mask[s] = CNT_W'(age) < count;
      end
   end

   for (genvar p = 0; p < NFWD; p++) begin : g_fwd
      wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd (
         .queue (queue),
         .valid (valid_mask),
         .head  (head),
         .raddr (fwd_raddr[5*p +: 5]),
         .hit   (fwd_hit[4*p +: 4]),
         .data  (fwd_data[32*p +: 32])
      );
   end
`else
   logic fwd_unused;
   assign fwd_unused = ^fwd_raddr;
   assign fwd_hit    = '0;
   assign fwd_data   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_mq.sv
// ============================================================================
// Module  : tb_wb_stage_mq
// Brief   : Self-checking bench for wb_stage_mq (queue model + directed cases).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_mq;

   logic         clk = 1'b0;
   logic         resetn = 1'b1;
   logic [1:0]   valid = '0;
   logic [147:0] bus = '0;
   logic         stall = 1'b0;
   logic [9:0]   fwd_raddr = '0;
   logic         ws_allowin, ws_empty;
   logic [3:0]   rf_we, dbg_wen;
   logic [4:0]   rf_waddr, dbg_wnum;
   logic [31:0]  rf_wdata, dbg_pc, dbg_wdata;
   logic [7:0]   fwd_hit;
   logic [63:0]  fwd_data;

   logic [1:0]   b_valid = '0;
   logic [147:0] b_bus = '0;
   logic         b_stall = 1'b0;
   logic [9:0]   b_fwd_raddr = '0;
   logic         b_allowin, b_empty;
   logic [7:0]   b_rf_we, b_dbg_wen, b_fwd_hit;
   logic [9:0]   b_rf_waddr, b_dbg_wnum;
   logic [63:0]  b_rf_wdata, b_dbg_pc, b_dbg_wdata;
   logic [63:0]  b_fwd_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_stage_mq dut (
      .clk(clk), .resetn(resetn), .ms_to_ws_valid(valid), .ms_to_ws_bus(bus),
      .ws_allowin(ws_allowin), .ws_stall(stall), .ws_empty(ws_empty),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .debug_wb_pc(dbg_pc), .debug_wb_rf_wen(dbg_wen),
      .debug_wb_rf_wnum(dbg_wnum), .debug_wb_rf_wdata(dbg_wdata)
   );

   wb_stage_mq #(.LANES(2), .DEPTH(4), .WPORTS(2), .NFWD(2)) dut2 (
      .clk(clk), .resetn(resetn), .ms_to_ws_valid(b_valid), .ms_to_ws_bus(b_bus),
      .ws_allowin(b_allowin), .ws_stall(b_stall), .ws_empty(b_empty),
      .rf_we(b_rf_we), .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata),
      .fwd_raddr(b_fwd_raddr), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data),
      .debug_wb_pc(b_dbg_pc), .debug_wb_rf_wen(b_dbg_wen),
      .debug_wb_rf_wnum(b_dbg_wnum), .debug_wb_rf_wdata(b_dbg_wdata)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [73:0] lane(input logic [3:0] wen, input logic gr, input logic [4:0] dest,
                                        input logic [31:0] data, input logic [31:0] pc);
      return {wen, gr, dest, data, pc};
   endfunction

   // Reference model: pending writes as an ordered list, oldest first
   typedef struct {
      logic [3:0]  wen;
      logic [4:0]  dest;
      logic [31:0] data;
      logic [31:0] pc;
   } ent_t;
   ent_t mq[$];

   always @(posedge clk or negedge resetn) begin
      int         sz;
      bit         allow;
      logic [73:0] l;
      if (!resetn) begin
         mq.delete();
      end else begin
         sz    = mq.size();
         allow = (4 - sz) >= 2;
         if (!stall && sz > 0) void'(mq.pop_front());
         if (valid != 2'b00 && allow) begin
            for (int i = 0; i < 2; i++) begin
               l = bus[74*i +: 74];
               if (valid[i] && l[69] && l[73:70] != 4'h0 && l[68:64] != 5'd0)
                  mq.push_back('{l[73:70], l[68:64], l[63:32], l[31:0]});
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0]  ew, eh;
      logic [31:0] ed;
      logic [4:0]  ra;
      ew = (!stall && mq.size() > 0) ? mq[0].wen : 4'h0;
      chk("empty", ws_empty, mq.size() == 0);
      chk("allowin", ws_allowin, (4 - mq.size()) >= 2);
      chk("rf_we", rf_we, ew);
      chk("dbg_wen", dbg_wen, ew);
      if (ew != 4'h0) begin
         chk("rf_waddr", rf_waddr, mq[0].dest);
         chk("rf_wdata", rf_wdata, mq[0].data);
         chk("dbg_pc", dbg_pc, mq[0].pc);
         chk("dbg_wnum", dbg_wnum, mq[0].dest);
         chk("dbg_wdata", dbg_wdata, mq[0].data);
      end
      for (int p = 0; p < 2; p++) begin
         ra = fwd_raddr[5*p +: 5];
         eh = '0;
         ed = '0;
`ifdef WS_FWD_EN
         if (ra != 5'd0) begin
            foreach (mq[i]) begin
               if (mq[i].dest == ra) begin
                  for (int b = 0; b < 4; b++) begin
                     if (mq[i].wen[b]) begin
                        eh[b] = 1'b1;
                        ed[8*b +: 8] = mq[i].data[8*b +: 8];
                     end
                  end
               end
            end
         end
`endif
         chk("fwd_hit", fwd_hit[4*p +: 4], eh);
         chk("fwd_data", fwd_data[32*p +: 32], ed);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // MEM-side behaviour: hold the bundle until the stage accepts it
   task automatic send(input logic [1:0] v, input logic [73:0] l1, input logic [73:0] l0);
      logic acc;
      int   guard;
      valid = v;
      bus   = {l1, l0};
      guard = 0;
      do begin
         @(negedge clk);
         acc = ws_allowin;
         step();
         guard++;
      end while (!acc && guard < 20);
      chk("send_accept", acc, 1'b1);
      valid = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #2 resetn = 1'b0;
      #1;
      chk("rst_empty", ws_empty, 1'b1);
      chk("rst_allowin", ws_allowin, 1'b1);
      chk("rst_rf_we", rf_we, 4'h0);
      chk("rst_fwd_hit", fwd_hit, 8'h00);
      chk("rst_b_empty", b_empty, 1'b1);
      step(); step();
      resetn = 1'b1;
      step();

      // Two lanes, single write port: one write per cycle in lane order
      send(2'b11, lane(4'hF, 1, 5'd6, 32'h22222222, 32'h104), lane(4'hF, 1, 5'd5, 32'h11111111, 32'h100));
      @(negedge clk);
      chk("r5_we", rf_we, 4'hF);
      chk("r5_addr", rf_waddr, 5'd5);
      chk("r5_data", rf_wdata, 32'h11111111);
      chk("r5_pc", dbg_pc, 32'h100);
      step();
      @(negedge clk);
      chk("r6_addr", rf_waddr, 5'd6);
      chk("r6_data", rf_wdata, 32'h22222222);
      chk("r6_pc", dbg_pc, 32'h104);
      step();

      // Filtered lanes: dest r0, gr_we=0, rf_wen=0
      send(2'b11, lane(4'hF, 0, 5'd3, 32'h33333333, 32'h108), lane(4'hF, 1, 5'd0, 32'h44444444, 32'h10C));
      send(2'b01, lane(4'hF, 1, 5'd8, 32'h55555555, 32'h110), lane(4'h0, 1, 5'd4, 32'h66666666, 32'h114));
      @(negedge clk);
      chk("filt_empty", ws_empty, 1'b1);
      chk("filt_we", rf_we, 4'h0);
      step();

      // Fill under stall, then release and watch allowin recover
      stall = 1'b1;
      send(2'b11, lane(4'hF, 1, 5'd2, 32'h0000_0002, 32'h200), lane(4'hF, 1, 5'd1, 32'h0000_0001, 32'h1FC));
      send(2'b11, lane(4'h3, 1, 5'd4, 32'h0000_0004, 32'h208), lane(4'hC, 1, 5'd3, 32'h0000_0003, 32'h204));
      fwd_raddr = {5'd3, 5'd2};
      @(negedge clk);
      chk("full_allowin", ws_allowin, 1'b0);
      chk("full_stall_we", rf_we, 4'h0);
      step();
      stall = 1'b0;
      @(negedge clk);
      chk("drain1_allowin", ws_allowin, 1'b0);
      chk("drain1_addr", rf_waddr, 5'd1);
      step();
      @(negedge clk);
      chk("drain2_allowin", ws_allowin, 1'b0);
      step();
      @(negedge clk);
      chk("drain3_allowin", ws_allowin, 1'b1);
      repeat (3) step();

      // Back-to-back bundles with concurrent drain; pointers wrap
      send(2'b11, lane(4'hF, 1, 5'd12, 32'hC0C0C0C0, 32'h300), lane(4'hF, 1, 5'd11, 32'hB0B0B0B0, 32'h2FC));
      send(2'b11, lane(4'h2, 1, 5'd12, 32'h0000AB00, 32'h308), lane(4'hF, 1, 5'd13, 32'hD0D0D0D0, 32'h304));
      fwd_raddr = {5'd13, 5'd12};
      send(2'b11, lane(4'hF, 1, 5'd16, 32'h16161616, 32'h310), lane(4'hF, 1, 5'd15, 32'h15151515, 32'h30C));
      send(2'b01, lane(4'hF, 1, 5'd18, 32'h18181818, 32'h318), lane(4'h1, 1, 5'd17, 32'h00000017, 32'h314));
      repeat (8) step();
      @(negedge clk);
      chk("wrap_empty", ws_empty, 1'b1);

      // Forwarding merge: younger byte-0 write overrides older full word
      step();
      stall = 1'b1;
      send(2'b11, lane(4'h1, 1, 5'd9, 32'h00000099, 32'h404), lane(4'hF, 1, 5'd9, 32'h12345678, 32'h400));
      fwd_raddr = {5'd10, 5'd9};
      @(negedge clk);
`ifdef WS_FWD_EN
      chk("fwd_r9_hit", fwd_hit[3:0], 4'hF);
      chk("fwd_r9_data", fwd_data[31:0], 32'h12345699);
`else
      chk("fwd_off_hit", fwd_hit[3:0], 4'h0);
      chk("fwd_off_data", fwd_data[31:0], 32'h0);
`endif
      chk("fwd_r10_hit", fwd_hit[7:4], 4'h0);
      step();
      stall = 1'b0;
      fwd_raddr = {5'd0, 5'd9};
      @(negedge clk);
`ifdef WS_FWD_EN
      chk("fwd_drain_data", fwd_data[31:0], 32'h12345699);
`endif
      chk("fwd_r0_hit", fwd_hit[7:4], 4'h0);
      repeat (3) step();

      // Two write ports: same-register collision, younger byte wins
      b_stall = 1'b1;
      b_valid = 2'b11;
      b_bus   = {lane(4'h1, 1, 5'd7, 32'h000000EE, 32'h504), lane(4'hF, 1, 5'd7, 32'hAABBCCDD, 32'h500)};
      step();
      b_valid = '0;
      step();
      b_stall = 1'b0;
      @(negedge clk);
      chk("wp2_we", b_rf_we, 8'h1E);
      chk("wp2_dbg_wen", b_dbg_wen, 8'h1E);
      chk("wp2_addr", b_rf_waddr, {5'd7, 5'd7});
      chk("wp2_data", b_rf_wdata, {32'h000000EE, 32'hAABBCCDD});
      chk("wp2_pc", b_dbg_pc, {32'h504, 32'h500});
      step();
      @(negedge clk);
      chk("wp2_empty", b_empty, 1'b1);
      chk("wp2_idle_we", b_rf_we, 8'h00);
      step();

      // Asynchronous reset with three entries pending
      stall = 1'b1;
      send(2'b11, lane(4'hF, 1, 5'd21, 32'h21212121, 32'h604), lane(4'hF, 1, 5'd20, 32'h20202020, 32'h600));
      send(2'b01, lane(4'hF, 1, 5'd23, 32'h23232323, 32'h60C), lane(4'hF, 1, 5'd22, 32'h22222222, 32'h608));
      stall = 1'b0;
      #1;
      chk("prerst_we", rf_we, 4'hF);
      #1 resetn = 1'b0;
      #1;
      chk("midrst_we", rf_we, 4'h0);
      chk("midrst_empty", ws_empty, 1'b1);
      chk("midrst_allowin", ws_allowin, 1'b1);
      step(); step();
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("postrst_we", rf_we, 4'h0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
